// File: rtl/reg_writeback_queue.sv
// rtl/reg_writeback_queue.sv - in-order writeback FIFO feeding the register bank write port, with youngest-match bypass
//
// Purpose: buffers WB-stage register writes and drains one per cycle onto the
// bank's single write port. Decode can read still-queued values via two bypass ports.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   wbValid/wbReady          writeback request handshake (wbReady = !full, 0 in reset)
//   wbAddr, wbData           destination register and value
//   hold                     1: bank port busy, do not drain this cycle
//   regWrite/write/writeData bank write port, driven from the head entry
//   fwdAddrA/B               bypass lookup addresses
//   fwdHitA/B, fwdDataA/B    bypass hit flags and youngest matching data (0 on miss)
//   count                    current occupancy
module reg_writeback_queue #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int DROP_R0 = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wbValid,
    output logic                       wbReady,
    input  logic [ADDR_W-1:0]          wbAddr,
    input  logic [DATA_W-1:0]          wbData,
    input  logic                       hold,
    output logic                       regWrite,
    output logic [ADDR_W-1:0]          write,
    output logic [DATA_W-1:0]          writeData,
    input  logic [ADDR_W-1:0]          fwdAddrA,
    input  logic [ADDR_W-1:0]          fwdAddrB,
    output logic                       fwdHitA,
    output logic                       fwdHitB,
    output logic [DATA_W-1:0]          fwdDataA,
    output logic [DATA_W-1:0]          fwdDataB,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic empty, full, is_r0, push, pop;
    logic [PTR_W-1:0] idx;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // Gated by rst so the handshake is closed while reset is held.
    assign wbReady = rst & ~full;

    // Writes to r0 complete the handshake but are never stored.
    assign is_r0 = (DROP_R0 != 0) && (wbAddr == '0);
    assign push  = wbValid & wbReady & ~is_r0;

    assign regWrite  = ~empty & ~hold;
    assign pop       = regWrite;
    assign write     = regWrite ? addr_q[head_q] : '0;
    assign writeData = regWrite ? data_q[head_q] : '0;
    assign count     = count_q;

    always_comb begin
        head_d  = pop  ? head_q + 1'b1 : head_q;
        tail_d  = push ? tail_q + 1'b1 : tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Walk entries oldest to youngest so later matches overwrite earlier ones.
    always_comb begin
        fwdHitA  = 1'b0;
        fwdHitB  = 1'b0;
        fwdDataA = '0;
        fwdDataB = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (valid_q[idx] && addr_q[idx] == fwdAddrA &&
                !((DROP_R0 != 0) && fwdAddrA == '0)) begin
                fwdHitA  = 1'b1;
                fwdDataA = data_q[idx];
            end
            if (valid_q[idx] && addr_q[idx] == fwdAddrB &&
                !((DROP_R0 != 0) && fwdAddrB == '0)) begin
                fwdHitB  = 1'b1;
                fwdDataB = data_q[idx];
            end
        end
    end

    // Push and pop never target the same slot: equal pointers mean empty
    // (no pop) or full (no push).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                addr_q[tail_q]  <= wbAddr;
                data_q[tail_q]  <= wbData;
                valid_q[tail_q] <= 1'b1;
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb/tb_reg_writeback_queue.sv - self-checking bench for reg_writeback_queue
module tb_reg_writeback_queue;

    logic        clk;
    logic        rst;
    logic        wbValid;
    logic        wbReady;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic        hold;
    logic        regWrite;
    logic [4:0]  write;
    logic [31:0] writeData;
    logic [4:0]  fwdAddrA;
    logic [4:0]  fwdAddrB;
    logic        fwdHitA;
    logic        fwdHitB;
    logic [31:0] fwdDataA;
    logic [31:0] fwdDataB;
    logic [2:0]  count;

    reg_writeback_queue #(
        .DEPTH(4), .ADDR_W(5), .DATA_W(32), .DROP_R0(1)
    ) dut (
        .clk(clk), .rst(rst),
        .wbValid(wbValid), .wbReady(wbReady), .wbAddr(wbAddr), .wbData(wbData),
        .hold(hold),
        .regWrite(regWrite), .write(write), .writeData(writeData),
        .fwdAddrA(fwdAddrA), .fwdAddrB(fwdAddrB),
        .fwdHitA(fwdHitA), .fwdHitB(fwdHitB),
        .fwdDataA(fwdDataA), .fwdDataB(fwdDataB),
        .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: reference queue of accepted writes, oldest at the front.
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;
    ent_t mq[$];
    bit   mon_en = 1'b0;

    task automatic model_fwd(input logic [4:0] a, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != 5'd0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].addr == a) begin
                    hit = 1'b1;
                    d   = mq[i].data;
                    break;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst) begin
                mq.delete();
                chk("rst_regWrite", {31'd0, regWrite}, 32'd0);
                chk("rst_wbReady",  {31'd0, wbReady},  32'd0);
                chk("rst_count",    {29'd0, count},    32'd0);
                chk("rst_fwdHitA",  {31'd0, fwdHitA},  32'd0);
                chk("rst_write",    {27'd0, write},    32'd0);
            end else begin
                logic        e_rdy, e_rw, e_ha, e_hb;
                logic [31:0] e_da, e_db;
                ent_t        h;
                e_rdy = (mq.size() != 4);
                e_rw  = (mq.size() != 0) && !hold;
                h.addr = '0;
                h.data = '0;
                if (e_rw) h = mq[0];
                model_fwd(fwdAddrA, e_ha, e_da);
                model_fwd(fwdAddrB, e_hb, e_db);
                chk("sb_wbReady",   {31'd0, wbReady},  {31'd0, e_rdy});
                chk("sb_count",     {29'd0, count},    mq.size());
                chk("sb_regWrite",  {31'd0, regWrite}, {31'd0, e_rw});
                chk("sb_write",     {27'd0, write},    {27'd0, h.addr});
                chk("sb_writeData", writeData,         h.data);
                chk("sb_fwdHitA",   {31'd0, fwdHitA},  {31'd0, e_ha});
                chk("sb_fwdDataA",  fwdDataA,          e_da);
                chk("sb_fwdHitB",   {31'd0, fwdHitB},  {31'd0, e_hb});
                chk("sb_fwdDataB",  fwdDataB,          e_db);
                if (e_rw) void'(mq.pop_front());
                if (wbValid && e_rdy && wbAddr != 5'd0) begin
                    ent_t n;
                    n.addr = wbAddr;
                    n.data = wbData;
                    mq.push_back(n);
                end
            end
        end
    end

    typedef struct {
        bit          v;
        logic [4:0]  a;
        logic [31:0] d;
        bit          h;
        logic [4:0]  fa, fb;
        int          cnt;
        bit          rdy, rw;
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          ha;
        logic [31:0] da;
        bit          hb;
        logic [31:0] db;
    } vec_t;

    function automatic vec_t mk(bit v, int a, int d, bit h, int fa, int fb, int cnt,
                                bit rdy, bit rw, int wa, int wd,
                                bit ha, int da, bit hb, int db);
        vec_t r;
        r.v = v; r.a = 5'(a); r.d = 32'(d); r.h = h;
        r.fa = 5'(fa); r.fb = 5'(fb); r.cnt = cnt; r.rdy = rdy; r.rw = rw;
        r.wa = 5'(wa); r.wd = 32'(wd); r.ha = ha; r.da = 32'(da); r.hb = hb; r.db = 32'(db);
        return r;
    endfunction

    vec_t vecs[21];

    initial begin
        //            v  a  d     h fa fb cnt rdy rw wa wd    ha da    hb db
        // single write after reset
        vecs[0]  = mk(1, 3, 'h11, 0, 3, 0, 0,  1,  0, 0, 0,    0, 0,    0, 0);
        vecs[1]  = mk(0, 0, 0,    0, 3, 0, 1,  1,  1, 3, 'h11, 1, 'h11, 0, 0);
        vecs[2]  = mk(0, 0, 0,    0, 3, 0, 0,  1,  0, 0, 0,    0, 0,    0, 0);
        // fill under hold, youngest-match bypass, full rejects
        vecs[3]  = mk(1, 5, 'hA,  1, 5, 9, 0,  1,  0, 0, 0,    0, 0,    0, 0);
        vecs[4]  = mk(1, 6, 'hB,  1, 5, 9, 1,  1,  0, 0, 0,    1, 'hA,  0, 0);
        vecs[5]  = mk(1, 5, 'hC,  1, 5, 9, 2,  1,  0, 0, 0,    1, 'hA,  0, 0);
        vecs[6]  = mk(1, 7, 'hD,  1, 5, 9, 3,  1,  0, 0, 0,    1, 'hC,  0, 0);
        vecs[7]  = mk(0, 0, 0,    1, 5, 9, 4,  0,  0, 0, 0,    1, 'hC,  0, 0);
        vecs[8]  = mk(1, 8, 'h99, 1, 7, 6, 4,  0,  0, 0, 0,    1, 'hD,  1, 'hB);
        vecs[9]  = mk(0, 0, 0,    1, 8, 6, 4,  0,  0, 0, 0,    0, 0,    1, 'hB);
        // release hold: four back-to-back bank writes, full queue still refuses
        vecs[10] = mk(1, 9, 'h77, 0, 5, 9, 4,  0,  1, 5, 'hA,  1, 'hC,  0, 0);
        vecs[11] = mk(0, 0, 0,    0, 5, 6, 3,  1,  1, 6, 'hB,  1, 'hC,  1, 'hB);
        vecs[12] = mk(0, 0, 0,    0, 5, 6, 2,  1,  1, 5, 'hC,  1, 'hC,  0, 0);
        vecs[13] = mk(0, 0, 0,    0, 5, 7, 1,  1,  1, 7, 'hD,  0, 0,    1, 'hD);
        vecs[14] = mk(0, 0, 0,    0, 9, 7, 0,  1,  0, 0, 0,    0, 0,    0, 0);
        // r0 writes are dropped
        vecs[15] = mk(1, 0, 'hFF, 0, 0, 0, 0,  1,  0, 0, 0,    0, 0,    0, 0);
        vecs[16] = mk(0, 0, 0,    0, 0, 0, 0,  1,  0, 0, 0,    0, 0,    0, 0);
        // simultaneous push and pop keeps count and order
        vecs[17] = mk(1, 4, 'h44, 0, 4, 0, 0,  1,  0, 0, 0,    0, 0,    0, 0);
        vecs[18] = mk(1, 4, 'h45, 0, 4, 0, 1,  1,  1, 4, 'h44, 1, 'h44, 0, 0);
        vecs[19] = mk(0, 0, 0,    0, 4, 0, 1,  1,  1, 4, 'h45, 1, 'h45, 0, 0);
        vecs[20] = mk(0, 0, 0,    0, 4, 0, 0,  1,  0, 0, 0,    0, 0,    0, 0);

        wbValid = 0; wbAddr = 0; wbData = 0; hold = 0; fwdAddrA = 0; fwdAddrB = 0;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        mon_en = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 21; i++) begin
            @(posedge clk);
            #1;
            wbValid = vecs[i].v; wbAddr = vecs[i].a; wbData = vecs[i].d; hold = vecs[i].h;
            fwdAddrA = vecs[i].fa; fwdAddrB = vecs[i].fb;
            @(negedge clk);
            chk($sformatf("v%0d_count", i),     {29'd0, count},    vecs[i].cnt);
            chk($sformatf("v%0d_wbReady", i),   {31'd0, wbReady},  {31'd0, vecs[i].rdy});
            chk($sformatf("v%0d_regWrite", i),  {31'd0, regWrite}, {31'd0, vecs[i].rw});
            chk($sformatf("v%0d_write", i),     {27'd0, write},    {27'd0, vecs[i].wa});
            chk($sformatf("v%0d_writeData", i), writeData,         vecs[i].wd);
            chk($sformatf("v%0d_fwdHitA", i),   {31'd0, fwdHitA},  {31'd0, vecs[i].ha});
            chk($sformatf("v%0d_fwdDataA", i),  fwdDataA,          vecs[i].da);
            chk($sformatf("v%0d_fwdHitB", i),   {31'd0, fwdHitB},  {31'd0, vecs[i].hb});
            chk($sformatf("v%0d_fwdDataB", i),  fwdDataB,          vecs[i].db);
        end

        // random traffic, checked by the scoreboard monitor
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            wbValid  = 1'($urandom_range(0, 1));
            wbAddr   = 5'($urandom_range(0, 7));
            wbData   = $urandom;
            hold     = ($urandom_range(0, 3) == 0);
            fwdAddrA = 5'($urandom_range(0, 7));
            fwdAddrB = 5'($urandom_range(0, 7));
        end
        @(posedge clk);
        #1 wbValid = 0; hold = 0;
        repeat (6) @(posedge clk);

        // reset mid-operation with three queued writes
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1 wbValid = 1; hold = 1; wbAddr = 5'(i); wbData = 32'(i * 'h100);
        end
        @(posedge clk);
        #1 wbValid = 0; hold = 0; fwdAddrA = 5'd2;
        #1 rst = 1'b0;
        #1;
        chk("midrst_count",    {29'd0, count},    32'd0);
        chk("midrst_regWrite", {31'd0, regWrite}, 32'd0);
        chk("midrst_writeData", writeData,        32'd0);
        chk("midrst_wbReady",  {31'd0, wbReady},  32'd0);
        chk("midrst_fwdHitA",  {31'd0, fwdHitA},  32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("postrst_regWrite", {31'd0, regWrite}, 32'd0);
            chk("postrst_count",    {29'd0, count},    32'd0);
        end

        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
